nios2_mul_unit: RTL and testbench
=================================

# nios2_mul_unit

Parametrised, pipelined integer multiplier for the NIOS2 core's multiply path. It computes the full 2×WIDTH product of two WIDTH-bit operands from four registered HALF×HALF partial products. It returns either the low word (mul) or the signed/unsigned high word (mulxss, mulxsu, mulxuu). It sits between the A-stage operand muxes and writeback, behind a valid/ready handshake, and carries a tag so the core can match results to destination registers.

## Interface
- WIDTH, 32, operand and result width; must be even and ≥ 8.
- TAG_W, 5, width of the pass-through tag (destination register index).
- HALF, WIDTH/2, derived localparam; not overridable.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset is synchronous and active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_op  in  2  0=MUL (low word), 1=MULXSS, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXUU.
- in_src1  in  WIDTH  operand A.
- in_src2  in  WIDTH  operand B.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_result  out  WIDTH  selected product word.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Stage 1 (S1) registers op, operands, and tag.
- Stage 2 (S2) registers four unsigned partial products: pp_ll=A[lo]·B[lo], pp_hl=A[hi]·B[lo], pp_lh=A[lo]·B[hi], pp_hh=A[hi]·B[hi], each 2·HALF bits.
- Stage 3 (S3) sums the partial products:
  - full = pp_ll + (pp_hl<<HALF) + (pp_lh<<HALF) + (pp_hh<<WIDTH), modulo 2^(2·WIDTH).
  - Signed correction applies to the high word only:
    - hi −= B when A is treated as signed and A[WIDTH−1]=1.
    - hi −= A when B is treated as signed and B[WIDTH−1]=1.
    - The subtractions are modulo 2^WIDTH.
  - A is signed for MULXSS and MULXSU. B is signed for MULXSS only.
- out_result is full[WIDTH−1:0] for MUL, otherwise the corrected high word. MUL ignores signedness.
- S3 drives out_result, out_tag, and out_valid directly.
- Each stage has a valid bit. Bubbles propagate and are not squeezed out.

## Timing
- Global enable: pipe_en = !s3_valid || out_ready.
  - in_ready = pipe_en (combinational).
  - All stages advance together when pipe_en=1 and hold otherwise.
- Latency:
  - An op accepted at edge N is presented with out_valid=1 after edge N+2.
  - It holds until the handshake completes.
- Throughput: one op per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0 and S3 full, in_ready=0.
  - Up to 3 ops are held in S1–S3 without loss or reordering.
  - out_result and out_tag are stable while out_valid && !out_ready.
- Simultaneous accept and consume in the same cycle is allowed and keeps full throughput.
- Reset:
  - Clears all stage valid bits and data registers.
  - After reset: out_valid=0, out_result=0, out_tag=0. in_ready=1 the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight ops; nothing is emitted for them.
- in_* values are sampled only on accept. Changes while in_ready=0 have no effect.

## Structure
- Shared package nios2_mul_pkg:
  - mul_op_e enum (MUL, MULXSS, MULXSU, MULXUU).
  - Function is_src1_signed(op).
  - Function is_src2_signed(op).
- Sub-module nios2_mul_pp:
  - One HALF×HALF unsigned multiplier with registered output and enable.
  - Instantiated four times in S2 so synthesis can map each to a dedicated multiplier block.
- Top level holds the valid/enable control, the S3 adder tree, the signed correction, and the word select.

## Test plan
- WIDTH=32, MUL, src1=0x00010003, src2=0x00020005 -> out_result=0x000B000F.
  - Same operands with MULXUU -> 0x00000002.
- src1=src2=0xFFFFFFFF:
  - MULXUU -> 0xFFFFFFFE.
  - MULXSS -> 0x00000000.
  - MUL -> 0x00000001.
- MULXSU, src1=0xFFFFFFFF, src2=0x00000002 -> 0xFFFFFFFF.
  - MULXSS, src1=src2=0x80000000 -> 0x40000000.
- Back-to-back ops with tags 1..6 and out_ready=0 for 5 cycles:
  - in_ready falls after 3 accepts; out_result and out_tag are held stable.
  - After out_ready=1, all 6 results emerge in tag order with correct values.
- Reset asserted with 2 ops in flight:
  - out_valid=0 the next cycle and no stale result ever appears.
  - A new op after reset returns after the 3-cycle latency.
- WIDTH=16: 1000 random ops in each mode compared against a 32-bit reference product, with random out_ready toggling.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the NIOS2 multiply unit: operation encoding and
// per-operation operand signedness.
// Purely declarative; no timing or flow-control content.
package nios2_mul_pkg;

  // Encoding matches the in_op port of nios2_mul_unit.
  typedef enum logic [1:0] {
    MUL    = 2'd0,  // low word, signedness irrelevant
    MULXSS = 2'd1,  // high word, src1 signed, src2 signed
    MULXSU = 2'd2,  // high word, src1 signed, src2 unsigned
    MULXUU = 2'd3   // high word, both unsigned
  } mul_op_e;

  function automatic logic is_src1_signed(mul_op_e op);
    return (op == MULXSS) || (op == MULXSU);
  endfunction

  function automatic logic is_src2_signed(mul_op_e op);
    return (op == MULXSS);
  endfunction

endpackage

// File: rtl/nios2_mul_pp.sv
// Purpose: one HALF x HALF unsigned multiplier with a registered product.
// Latency: 1 cycle from operands to p_o; register holds while en_i=0.
// Backpressure: none of its own; the parent gates en_i with the pipe enable.
// Ports: clk, reset (sync, active-high), en_i load enable, a_i/b_i operands,
//        p_o registered 2*HALF-bit product.
module nios2_mul_pp #(
  parameter int HALF = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [HALF-1:0]   a_i,
  input  logic [HALF-1:0]   b_i,
  output logic [2*HALF-1:0] p_o
);

  logic [2*HALF-1:0] p_d;
  logic [2*HALF-1:0] p_q;

  // Operands are zero-extended so the multiply is unsigned and full width.
  always_comb begin
    p_d = {{HALF{1'b0}}, a_i} * {{HALF{1'b0}}, b_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios2_mul_unit.sv
// Purpose: 3-stage pipelined WIDTH x WIDTH multiplier returning the low word
//          (MUL) or the signed/unsigned high word (MULXSS/MULXSU/MULXUU).
// Latency: op accepted at edge N shows out_valid=1 after edge N+2; 1 op/cycle.
// Backpressure: single global enable; all stages stall when S3 holds an
//          unconsumed result, and in_ready drops with it (combinational).
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_op/in_src1/
//        in_src2/in_tag request side; out_valid/out_ready/out_result/out_tag
//        result side. WIDTH must be even and >= 8.
module nios2_mul_unit
  import nios2_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HALF = WIDTH / 2;

  logic pipe_en;

  // S1: registered request
  logic             s1_vld_q;
  mul_op_e          s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S2: partial products plus what S3 still needs (op, operands for the
  // signed correction, tag)
  logic             s2_vld_q;
  mul_op_e          s2_op_q;
  logic [WIDTH-1:0] s2_a_q;
  logic [WIDTH-1:0] s2_b_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [WIDTH-1:0] pp_ll;
  logic [WIDTH-1:0] pp_hl;
  logic [WIDTH-1:0] pp_lh;
  logic [WIDTH-1:0] pp_hh;

  // S3: final result
  logic             s3_vld_q;
  logic [WIDTH-1:0] s3_res_d;
  logic [WIDTH-1:0] s3_res_q;
  logic [TAG_W-1:0] s3_tag_q;

  // Stages never compress bubbles, so the only stall source is an
  // unconsumed result in S3.
  assign pipe_en  = !s3_vld_q || out_ready;
  assign in_ready = pipe_en;

  // Data registers load only when the incoming stage slot is valid, so a
  // result stays put under backpressure and bubbles never disturb data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= MUL;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_op_q  <= MUL;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_tag_q <= '0;
      s3_vld_q <= 1'b0;
      s3_res_q <= '0;
      s3_tag_q <= '0;
    end else if (pipe_en) begin
      s1_vld_q <= in_valid;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      if (in_valid) begin
        s1_op_q  <= mul_op_e'(in_op);
        s1_a_q   <= in_src1;
        s1_b_q   <= in_src2;
        s1_tag_q <= in_tag;
      end
      if (s1_vld_q) begin
        s2_op_q  <= s1_op_q;
        s2_a_q   <= s1_a_q;
        s2_b_q   <= s1_b_q;
        s2_tag_q <= s1_tag_q;
      end
      if (s2_vld_q) begin
        s3_res_q <= s3_res_d;
        s3_tag_q <= s2_tag_q;
      end
    end
  end

  // Four separate instances so each maps onto its own hard multiplier.
  nios2_mul_pp #(.HALF(HALF)) u_pp_ll (
    .clk(clk), .reset(reset), .en_i(pipe_en && s1_vld_q),
    .a_i(s1_a_q[HALF-1:0]), .b_i(s1_b_q[HALF-1:0]), .p_o(pp_ll)
  );
  nios2_mul_pp #(.HALF(HALF)) u_pp_hl (
    .clk(clk), .reset(reset), .en_i(pipe_en && s1_vld_q),
    .a_i(s1_a_q[WIDTH-1:HALF]), .b_i(s1_b_q[HALF-1:0]), .p_o(pp_hl)
  );
  nios2_mul_pp #(.HALF(HALF)) u_pp_lh (
    .clk(clk), .reset(reset), .en_i(pipe_en && s1_vld_q),
    .a_i(s1_a_q[HALF-1:0]), .b_i(s1_b_q[WIDTH-1:HALF]), .p_o(pp_lh)
  );
  nios2_mul_pp #(.HALF(HALF)) u_pp_hh (
    .clk(clk), .reset(reset), .en_i(pipe_en && s1_vld_q),
    .a_i(s1_a_q[WIDTH-1:HALF]), .b_i(s1_b_q[WIDTH-1:HALF]), .p_o(pp_hh)
  );

  // Unsigned full product, then two's-complement fix-up of the high word:
  // a negative signed operand contributes -2^WIDTH times the other operand.
  logic [2*WIDTH-1:0] full;
  logic [WIDTH-1:0]   hi;

  always_comb begin
    full = {{WIDTH{1'b0}}, pp_ll}
         + ({{WIDTH{1'b0}}, pp_hl} << HALF)
         + ({{WIDTH{1'b0}}, pp_lh} << HALF)
         + {pp_hh, {WIDTH{1'b0}}};
    hi = full[2*WIDTH-1:WIDTH];
    if (is_src1_signed(s2_op_q) && s2_a_q[WIDTH-1]) begin
      hi = hi - s2_b_q;
    end
    if (is_src2_signed(s2_op_q) && s2_b_q[WIDTH-1]) begin
      hi = hi - s2_a_q;
    end
    s3_res_d = (s2_op_q == MUL) ? full[WIDTH-1:0] : hi;
  end

  assign out_valid  = s3_vld_q;
  assign out_result = s3_res_q;
  assign out_tag    = s3_tag_q;

endmodule

// File: tb/tb_nios2_mul_unit.sv
`timescale 1ns/1ps
module tb_nios2_mul_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 32-bit instance
  logic        w32_in_valid, w32_in_ready, w32_out_valid, w32_out_ready;
  logic [1:0]  w32_in_op;
  logic [31:0] w32_in_src1, w32_in_src2, w32_out_result;
  logic [4:0]  w32_in_tag, w32_out_tag;

  // 16-bit instance
  logic        w16_in_valid, w16_in_ready, w16_out_valid, w16_out_ready;
  logic [1:0]  w16_in_op;
  logic [15:0] w16_in_src1, w16_in_src2, w16_out_result;
  logic [4:0]  w16_in_tag, w16_out_tag;

  int n_checks = 0;
  int n_errors = 0;

  nios2_mul_unit #(.WIDTH(32), .TAG_W(5)) u_w32 (
    .clk(clk), .reset(reset),
    .in_valid(w32_in_valid), .in_ready(w32_in_ready), .in_op(w32_in_op),
    .in_src1(w32_in_src1), .in_src2(w32_in_src2), .in_tag(w32_in_tag),
    .out_valid(w32_out_valid), .out_ready(w32_out_ready),
    .out_result(w32_out_result), .out_tag(w32_out_tag)
  );

  nios2_mul_unit #(.WIDTH(16), .TAG_W(5)) u_w16 (
    .clk(clk), .reset(reset),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_op(w16_in_op),
    .in_src1(w16_in_src1), .in_src2(w16_in_src2), .in_tag(w16_in_tag),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready),
    .out_result(w16_out_result), .out_tag(w16_out_tag)
  );

  // Reference: sign- or zero-extend each operand to double width, take the
  // ordinary product, and pick the requested word.
  function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [15:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] xa, xb, p;
    xa = (op == 2'd1 || op == 2'd2) ? {{16{a[15]}}, a} : {16'd0, a};
    xb = (op == 2'd1) ? {{16{b[15]}}, b} : {16'd0, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[15:0] : p[31:16];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    w32_in_valid = 1'b0; w32_in_op = 2'd0; w32_in_src1 = '0; w32_in_src2 = '0; w32_in_tag = '0;
    w16_in_valid = 1'b0; w16_in_op = 2'd0; w16_in_src1 = '0; w16_in_src2 = '0; w16_in_tag = '0;
    w32_out_ready = 1'b1; w16_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", w32_out_valid); end
    n_checks++; if (w32_out_result !== 32'd0) begin n_errors++; $display("FAIL reset_out_result: got %h want 0", w32_out_result); end
    n_checks++; if (w32_out_tag !== 5'd0) begin n_errors++; $display("FAIL reset_out_tag: got %h want 0", w32_out_tag); end
    n_checks++; if (w16_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_w16_out_valid: got %b want 0", w16_out_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (w32_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", w32_in_ready); end
    n_checks++; if (w16_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_w16_in_ready: got %b want 1", w16_in_ready); end
    n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_out_valid: got %b want 0", w32_out_valid); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7];
    logic [31:0] xs  [7];
    logic [31:0] ys  [7];
    logic [31:0] es  [7];
    ops = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};
    xs  = '{32'h00010003, 32'h00010003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    ys  = '{32'h00020005, 32'h00020005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h80000000};
    es  = '{32'h000B000F, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h40000000};
    w32_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      w32_in_valid = 1'b1; w32_in_op = ops[i]; w32_in_src1 = xs[i]; w32_in_src2 = ys[i];
      w32_in_tag = 5'(i + 8);
      #1;
      n_checks++; if (w32_in_ready !== 1'b1) begin n_errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, w32_in_ready); end
      @(posedge clk); #1;
      // Scramble inputs after accept: they must not leak into the result.
      w32_in_valid = 1'b0; w32_in_src1 = $urandom; w32_in_src2 = $urandom; w32_in_op = 2'($urandom_range(0, 3));
      n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL dir%0d_lat_n: got %b want 0", i, w32_out_valid); end
      @(posedge clk); #1;
      n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL dir%0d_lat_n1: got %b want 0", i, w32_out_valid); end
      @(posedge clk); #1;
      n_checks++; if (w32_out_valid !== 1'b1) begin n_errors++; $display("FAIL dir%0d_lat_n2: got %b want 1", i, w32_out_valid); end
      n_checks++; if (w32_out_result !== es[i]) begin n_errors++; $display("FAIL dir%0d_result: got %h want %h", i, w32_out_result, es[i]); end
      n_checks++; if (w32_out_tag !== 5'(i + 8)) begin n_errors++; $display("FAIL dir%0d_tag: got %0d want %0d", i, w32_out_tag, i + 8); end
      @(posedge clk); #1;
      n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL dir%0d_drain: got %b want 0", i, w32_out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [8];
    logic [31:0] xs  [8];
    logic [31:0] ys  [8];
    w32_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ops[i] = 2'(i % 4); xs[i] = $urandom; ys[i] = $urandom;
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      w32_in_valid = (cyc < 8);
      if (cyc < 8) begin
        w32_in_op = ops[cyc]; w32_in_src1 = xs[cyc]; w32_in_src2 = ys[cyc]; w32_in_tag = 5'(cyc);
      end
      #1;
      if (cyc < 8) begin
        n_checks++; if (w32_in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready c%0d: got %b want 1", cyc, w32_in_ready); end
      end
      if (cyc >= 3 && cyc < 11) begin
        n_checks++;
        if (w32_out_valid !== 1'b1 || w32_out_tag !== 5'(cyc - 3) ||
            w32_out_result !== ref32(ops[cyc-3], xs[cyc-3], ys[cyc-3])) begin
          n_errors++;
          $display("FAIL b2b_out c%0d: got v=%b tag=%0d res=%h want v=1 tag=%0d res=%h", cyc,
                   w32_out_valid, w32_out_tag, w32_out_result, cyc - 3,
                   ref32(ops[cyc-3], xs[cyc-3], ys[cyc-3]));
        end
      end
      if (cyc == 11) begin
        n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", w32_out_valid); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  ops [6];
    logic [31:0] xs  [6];
    logic [31:0] ys  [6];
    int          sent, got;
    logic        have_held;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    for (int i = 0; i < 6; i++) begin
      ops[i] = 2'($urandom_range(0, 3)); xs[i] = $urandom; ys[i] = $urandom;
    end
    sent = 0; got = 0; have_held = 1'b0; held_res = '0; held_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      w32_out_ready = (cyc >= 5);
      w32_in_valid  = (sent < 6);
      if (sent < 6) begin
        w32_in_op = ops[sent]; w32_in_src1 = xs[sent]; w32_in_src2 = ys[sent]; w32_in_tag = 5'(sent + 1);
      end
      #1;
      if (cyc < 5) begin
        n_checks++; if (w32_in_ready !== (cyc < 3)) begin n_errors++; $display("FAIL bp_in_ready c%0d: got %b want %b", cyc, w32_in_ready, cyc < 3); end
        n_checks++; if (sent !== ((cyc < 3) ? cyc : 3)) begin n_errors++; $display("FAIL bp_accepts c%0d: got %0d want %0d", cyc, sent, (cyc < 3) ? cyc : 3); end
      end
      if (w32_out_valid && !w32_out_ready) begin
        if (have_held) begin
          n_checks++;
          if (w32_out_result !== held_res || w32_out_tag !== held_tag) begin
            n_errors++;
            $display("FAIL bp_hold c%0d: got %h/%0d want %h/%0d", cyc, w32_out_result, w32_out_tag, held_res, held_tag);
          end
        end else begin
          have_held = 1'b1; held_res = w32_out_result; held_tag = w32_out_tag;
        end
      end
      if (w32_out_valid && w32_out_ready) begin
        n_checks++;
        if (w32_out_tag !== 5'(got + 1) || w32_out_result !== ref32(ops[got], xs[got], ys[got])) begin
          n_errors++;
          $display("FAIL bp_result %0d: got tag=%0d res=%h want tag=%0d res=%h", got, w32_out_tag,
                   w32_out_result, got + 1, ref32(ops[got], xs[got], ys[got]));
        end
        got++;
      end
      if (w32_in_valid && w32_in_ready) sent++;
      @(posedge clk); #1;
    end
    w32_in_valid = 1'b0;
    w32_out_ready = 1'b1;
    n_checks++; if (got !== 6) begin n_errors++; $display("FAIL bp_timeout: got %0d results want 6", got); end
  endtask

  task automatic test_reset_midflight();
    int          stale;
    logic [31:0] x, y;
    w32_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w32_in_valid = 1'b1; w32_in_op = 2'd0; w32_in_src1 = $urandom; w32_in_src2 = $urandom;
      w32_in_tag = 5'(20 + i);
      @(posedge clk); #1;
    end
    w32_in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_out_valid: got %b want 0", w32_out_valid); end
    reset = 1'b0;
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (w32_out_valid !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_errors++; $display("FAIL rst_mid_stale: got %0d stale cycles want 0", stale); end
    x = $urandom; y = $urandom;
    w32_in_valid = 1'b1; w32_in_op = 2'd1; w32_in_src1 = x; w32_in_src2 = y; w32_in_tag = 5'd29;
    @(posedge clk); #1;
    w32_in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (w32_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_new_early: got %b want 0", w32_out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (w32_out_valid !== 1'b1 || w32_out_result !== ref32(2'd1, x, y) || w32_out_tag !== 5'd29) begin
      n_errors++;
      $display("FAIL rst_new_result: got v=%b res=%h tag=%0d want v=1 res=%h tag=29", w32_out_valid,
               w32_out_result, w32_out_tag, ref32(2'd1, x, y));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random16();
    logic [15:0] exp_res [$];
    logic [4:0]  exp_tag [$];
    logic [15:0] er;
    logic [4:0]  et;
    int          sent, got, cyc;
    for (int mode = 0; mode < 4; mode++) begin
      sent = 0; got = 0; cyc = 0;
      exp_res.delete(); exp_tag.delete();
      while (got < 1000 && cyc < 12000) begin
        w16_out_ready = ($urandom_range(0, 99) < 70);
        w16_in_valid  = (sent < 1000) && ($urandom_range(0, 99) < 80);
        w16_in_op     = 2'(mode);
        w16_in_src1   = 16'($urandom);
        w16_in_src2   = 16'($urandom);
        w16_in_tag    = 5'($urandom);
        #1;
        if (w16_out_valid && w16_out_ready) begin
          n_checks++;
          if (exp_res.size() == 0) begin
            n_errors++; $display("FAIL r16_m%0d_unexpected: got res=%h with no op pending", mode, w16_out_result);
          end else begin
            er = exp_res.pop_front(); et = exp_tag.pop_front();
            if (w16_out_result !== er || w16_out_tag !== et) begin
              n_errors++;
              $display("FAIL r16_m%0d_result #%0d: got %h/%0d want %h/%0d", mode, got, w16_out_result, w16_out_tag, er, et);
            end
          end
          got++;
        end
        if (w16_in_valid && w16_in_ready) begin
          exp_res.push_back(ref16(w16_in_op, w16_in_src1, w16_in_src2));
          exp_tag.push_back(w16_in_tag);
          sent++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      w16_in_valid = 1'b0;
      n_checks++; if (got !== 1000 || exp_res.size() !== 0) begin n_errors++; $display("FAIL r16_m%0d_count: got %0d results, %0d pending, want 1000/0", mode, got, exp_res.size()); end
    end
    w16_out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
